// File: rtl/des_word_aligner.sv
// des_word_aligner
// Converts a bit-serial stream (LSB first, qualified by in_valid) into
// WIDTH-bit words. Word boundaries are found by hunting for COMMA on every
// received bit, then confirmed by LOCK_CNT consecutive commas on the
// candidate boundary. Once locked, non-comma boundary words are queued in a
// show-ahead FIFO with a valid/ready output. Too many off-boundary commas
// while locked drop the aligner back to hunting.
//
// Ports:
//   clk        single clock, posedge
//   rst_n      asynchronous active-low reset
//   in_data    serial bit, sampled when in_valid=1
//   in_valid   bit enable
//   out_data   FIFO head word (0 while empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accept; pop on out_valid && out_ready
//   locked     aligner is in LOCKED state
//   full       FIFO holds DEPTH words
//   overflow   sticky: a word was dropped because the FIFO was full
//   clr_ovf    single-cycle pulse clearing overflow
module des_word_aligner #(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] COMMA        = WIDTH'(8'hBC),
    parameter int unsigned      LOCK_CNT     = 3,
    parameter int unsigned      MISALIGN_MAX = 2,
    parameter int unsigned      DEPTH        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             full,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       comma_cnt_q, comma_cnt_d;
    logic [3:0]       misalign_q, misalign_d;
    logic             locked_q, locked_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [WIDTH-1:0] sr_shift;
    logic             comma_hit;
    logic             boundary;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             empty;
    logic             full_now;
    logic [PW-1:0]    count;

    // Alignment state machine. The word examined on every bit is the
    // post-shift register, so a comma is recognised in the same cycle its
    // last bit arrives.
    always_comb begin
        sr_shift    = {in_data, sr_q[WIDTH-1:1]};
        comma_hit   = (sr_shift == COMMA);
        boundary    = in_valid && (bitcnt_q == CW'(WIDTH - 1));

        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        misalign_d  = misalign_q;
        push_req    = 1'b0;

        if (in_valid) begin
            sr_d     = sr_shift;
            bitcnt_d = (bitcnt_q == CW'(WIDTH - 1)) ? '0 : bitcnt_q + CW'(1);
            unique case (state_q)
                HUNT: begin
                    // A comma anywhere defines the new boundary grid.
                    if (comma_hit) begin
                        bitcnt_d    = '0;
                        comma_cnt_d = 4'd1;
                        misalign_d  = '0;
                        state_d     = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary) begin
                        if (comma_hit) begin
                            comma_cnt_d = comma_cnt_q + 4'd1;
                            if ((comma_cnt_q + 4'd1) == 4'(LOCK_CNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            comma_cnt_d = '0;
                            state_d     = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        if (comma_hit) begin
                            misalign_d = '0;
                        end else begin
                            push_req = 1'b1;
                        end
                    end else if (comma_hit) begin
                        // Off-grid commas suggest the boundary has slipped.
                        if ((misalign_q + 4'd1) == 4'(MISALIGN_MAX)) begin
                            misalign_d = '0;
                            state_d    = HUNT;
                        end else begin
                            misalign_d = misalign_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    // FIFO bookkeeping. A pop in the same cycle frees room for a push into a
    // full FIFO; there is no bypass, so a push into an empty FIFO becomes
    // visible on the following cycle.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        full_now = (count == PW'(DEPTH));
        pop      = !empty && out_ready;
        push_ok  = push_req && (!full_now || pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        // A drop in the same cycle as clr_ovf keeps the flag set.
        if (push_req && full_now && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bitcnt_q    <= '0;
            comma_cnt_q <= '0;
            misalign_q  <= '0;
            locked_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            comma_cnt_q <= comma_cnt_d;
            misalign_q  <= misalign_d;
            locked_q    <= locked_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= sr_shift;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign locked    = locked_q;
    assign full      = full_now;
    assign overflow  = overflow_q;

endmodule
